pwm_gen: RTL
============

Name: pwm_gen

Overview:
- Generates the PWM `pulse` that the switch/H-bridge enable stage gates onto EN[1:0].
- Consumes the 12-bit `duty` word produced by the switch stage (sw[7:4]*255, range 0..3825).
- Free-running prescaled period counter; duty is shadow-latched only at period boundaries, so no runt pulses occur.
- Optional soft-start ramps the applied duty upward to limit inrush into the motors.

Parameters:
- CNT_W, 12: width of the period counter and of the duty words.
- PERIOD, 4096: counts per PWM period; counter runs 0..PERIOD-1. Legal range 2..2^CNT_W.
- PRESCALE, 8: clk cycles per counter tick; 1 = tick every clk. Default gives ~3.05 kHz at 100 MHz.
- RAMP_STEP, 64: soft-start increment per period (used only with the macro).

Ports:
- clk, input, 1: system clock. The block has one clock; reset is synchronous and active-high.
- rst, input, 1: synchronous, active-high reset.
- enable, input, 1: run request (sw[0] level).
- duty_in, input, CNT_W: target duty, in counts high per period.
- pulse, output, 1: registered PWM output.
- period_start, output, 1: one-clk strobe on the first clk of each new period.
- active_duty, output, CNT_W: duty currently being applied, for observability and debug.

Behaviour:
- Reset: while rst=1 at a clk edge, clear pre_cnt, cnt, active_duty, pulse and period_start to 0. The first period begins on the clk after rst deasserts. rst asserted mid-period aborts the period immediately, with no completion.
- Prescaler:
  - pre_cnt counts 0..PRESCALE-1.
  - tick = (pre_cnt == PRESCALE-1).
  - With PRESCALE=1, tick is constantly 1.
- Period counter:
  - cnt advances on tick.
  - wrap = tick && (cnt == PERIOD-1); on wrap, cnt goes to 0.
  - No other value is ever reached.
- period_start: registered; equals 1 for exactly one clk, the clk on which cnt first reads 0 after a wrap. It is 0 after reset until the first wrap.
- Duty clamp: tgt = (duty_in >= PERIOD) ? PERIOD : duty_in. Comparison is done at CNT_W+1 bits so that PERIOD=2^CNT_W is handled.
- Shadow update on wrap only, when no macro is defined: active_duty <= tgt. Changes to duty_in mid-period have no effect until the next wrap.
- enable=0: active_duty <= 0 on the next clk regardless of wrap, and pulse is forced low. The counters keep running, so period_start continues.
- enable rising edge: active_duty stays 0 until the next wrap, then loads per the update rule.
- pulse <= enable && (cnt < active_duty). This is a registered compare, so pulse lags cnt by 1 clk.
  - active_duty = 0: pulse is never high.
  - active_duty = PERIOD: pulse is constantly high (100%).
- Simultaneous wrap and enable=0: the enable=0 clear wins.
- Simultaneous wrap and rst=1: rst wins.

Optional Feature:
- Macro: PWM_SOFT_START_EN.
- Defined — on wrap (with enable=1):
  - If tgt > active_duty: active_duty <= min(active_duty + RAMP_STEP, tgt). The sum is computed at CNT_W+1 bits, with no overflow wrap.
  - If tgt <= active_duty: active_duty <= tgt immediately. Deceleration is never ramped.
- Not defined: active_duty <= tgt on every wrap, i.e. a step change.
- All other behaviour is identical in both builds.

Test Plan (bench parameters PERIOD=16, PRESCALE=1, CNT_W=12, RAMP_STEP=4 unless noted):
- Reset: hold rst 3 clks with enable=1 and duty_in=8 -> pulse=0, period_start=0, active_duty=0 throughout. The first period_start occurs 16 clks after rst drops.
- Steady duty, no macro: enable=1, duty_in=5 -> after the first wrap, each 16-clk period has pulse high 5 clks and low 11 clks. The high window starts 1 clk after period_start.
- Mid-period change: while active_duty=5, set duty_in=12 at cnt=3 -> the current period stays at 5 high clks and the next period has 12 high clks.
- Boundaries:
  - duty_in=0 -> pulse never high.
  - duty_in=16 -> pulse high all 16 clks.
  - duty_in=3825 -> clamped to 16 (pulse constantly high), active_duty=16.
- Enable drop: enable goes to 0 mid-high -> pulse=0 on the next clk, active_duty=0, and period_start keeps its 16-clk cadence.
- Soft-start (PWM_SOFT_START_EN, duty_in=14, enable=1) -> active_duty takes 4, 8, 12, 14 on successive wraps. Then with duty_in=2, active_duty becomes 2 at the next wrap.

Source files
------------

// File: rtl/pwm_gen.sv
// pwm_gen: prescaled, free-running PWM generator with period-boundary duty shadowing.
// The duty word is clamped to PERIOD and latched only when a period wraps, so a
// mid-period duty change never produces a runt pulse.
// Optional soft-start ramp: define PWM_SOFT_START_EN to ramp the applied duty upward
// by RAMP_STEP per period. Deceleration is always applied immediately.
module pwm_gen #(
    parameter int CNT_W     = 12,
    parameter int PERIOD    = 4096,
    parameter int PRESCALE  = 8,
    parameter int RAMP_STEP = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [CNT_W-1:0] duty_in,
    output logic             pulse,
    output logic             period_start,
    output logic [CNT_W-1:0] active_duty
);

`ifdef PWM_SOFT_START_EN
    localparam bit SOFT_START = 1'b1;
`else
    localparam bit SOFT_START = 1'b0;
`endif

    // Prescaler needs at least one bit even when PRESCALE=1 (tick is then constant).
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
    // Duty values live at CNT_W+1 bits so that PERIOD = 2^CNT_W (100%) is representable.
    localparam logic [CNT_W:0]   PERIOD_W = (CNT_W + 1)'(PERIOD);
    localparam logic [CNT_W:0]   STEP_W   = (CNT_W + 1)'(RAMP_STEP);

    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [CNT_W:0]   duty_q,    duty_d;
    logic             pulse_q,   pulse_d;
    logic             pstart_q,  pstart_d;

    logic             tick;
    logic             wrap;
    logic [CNT_W:0]   duty_ext;
    logic [CNT_W:0]   tgt;
    logic [CNT_W:0]   ramp_sum;
    logic [CNT_W:0]   ramp_val;

    assign tick = (pre_cnt_q == PRE_LAST);
    assign wrap = tick && (cnt_q == CNT_LAST);

    // Clamp the requested duty to a full period.
    always_comb begin
        duty_ext = {1'b0, duty_in};
        tgt      = (duty_ext >= PERIOD_W) ? PERIOD_W : duty_ext;
    end

    // Soft-start candidate: one RAMP_STEP above the applied duty, never past the target.
    // Only reached while duty_q < tgt <= PERIOD, so the sum cannot overflow CNT_W+1 bits.
    always_comb begin
        ramp_sum = duty_q + STEP_W;
        ramp_val = (ramp_sum < tgt) ? ramp_sum : tgt;
    end

    // Prescaler and period counter next state.
    always_comb begin
        pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
        cnt_d     = cnt_q;
        if (wrap) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Applied duty: cleared by enable low, otherwise reloaded only at a wrap.
    always_comb begin
        duty_d = duty_q;
        if (!enable) begin
            duty_d = '0;
        end else if (wrap) begin
            if (SOFT_START && (tgt > duty_q)) begin
                duty_d = ramp_val;
            end else begin
                duty_d = tgt;
            end
        end
    end

    // Registered compare and period strobe; the strobe lands on the clk where cnt reads 0.
    always_comb begin
        pulse_d  = enable && ({1'b0, cnt_q} < duty_q);
        pstart_d = wrap;
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_q <= '0;
            cnt_q     <= '0;
            duty_q    <= '0;
            pulse_q   <= 1'b0;
            pstart_q  <= 1'b0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            cnt_q     <= cnt_d;
            duty_q    <= duty_d;
            pulse_q   <= pulse_d;
            pstart_q  <= pstart_d;
        end
    end

    assign pulse        = pulse_q;
    assign period_start = pstart_q;
    // A full-scale duty of 2^CNT_W does not fit the debug port; show it saturated.
    assign active_duty  = duty_q[CNT_W] ? {CNT_W{1'b1}} : duty_q[CNT_W-1:0];

endmodule
